// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - request/response bundle for the HI/LO multiply/divide unit
//
// Purpose : groups the request handshake and the HI/LO result signals of muldiv_ctrl.
// Signals : req, op[2:0], a, b, flush (requester -> unit)
//           ready, busy, done, hi, lo (unit -> requester)
// Modports: master = requester side, slave = muldiv_ctrl side
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output req, op, a, b, flush,
        input  ready, busy, done, hi, lo
    );

    modport slave (
        input  req, op, a, b, flush,
        output ready, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative MULT/MULTU/DIV/DIVU and MTHI/MTLO unit holding HI/LO
//
// Purpose : one shared shift/add-subtract datapath for MIPS multiply/divide, with
//           architectural HI/LO registers and a busy stall output.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous active-low reset
//           bus    - muldiv_ctrl_if.slave (req/op/a/b/flush in, ready/busy/done/hi/lo out)
// Options : MULDIV_FAST_MUL_EN - when defined, MULT/MULTU use a single combinational
//           multiply at accept and skip the iterative phase.
module muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_is_div;
    logic             r_sa;
    logic             r_sb;
    // Multiply: {r_acc_hi,r_acc_lo} is the product register, multiplier starts in r_acc_lo.
    // Divide  : r_acc_hi is the remainder, r_acc_lo shifts dividend bits out and quotient bits in.
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_opb;

    logic             w_accept;
    logic             w_signed;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // flush in IDLE blocks acceptance, including MT writes
    assign w_accept = bus.req && (r_state == S_IDLE) && !bus.flush;
    assign w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign w_sa     = w_signed && bus.a[WIDTH-1];
    assign w_sb     = w_signed && bus.b[WIDTH-1];
    assign w_mag_a  = w_sa ? (~bus.a + 1'b1) : bus.a;
    assign w_mag_b  = w_sb ? (~bus.b + 1'b1) : bus.b;

    // multiply step: conditional add into the upper half, carry kept for the right shift
    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : '0);

    // restoring divide step; the shifted remainder can reach WIDTH+1 bits
    assign w_rem_sh = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_q_bit  = (w_rem_sh >= {1'b0, r_opb});
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_opb;

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = (r_sa ^ r_sb) ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_fix  = (r_sa ^ r_sb) ? (~r_acc_lo + 1'b1) : r_acc_lo;
    assign w_rem_fix  = r_sa ? (~r_acc_hi + 1'b1) : r_acc_hi;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_is_div <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opb    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (bus.op)
                            OP_MTHI: begin
                                r_hi   <= bus.a;
                                r_done <= 1'b1;
                            end
                            OP_MTLO: begin
                                r_lo   <= bus.a;
                                r_done <= 1'b1;
                            end
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_sa     <= w_sa;
                                r_sb     <= w_sb;
                                r_is_div <= bus.op[1];
                                r_cnt    <= '0;
`ifdef MULDIV_FAST_MUL_EN
                                if (!bus.op[1]) begin
                                    r_acc_hi <= w_fast_prod[2*WIDTH-1:WIDTH];
                                    r_acc_lo <= w_fast_prod[WIDTH-1:0];
                                    r_state  <= S_FIX;
                                end else begin
                                    r_acc_hi <= '0;
                                    r_acc_lo <= w_mag_a;
                                    r_opb    <= w_mag_b;
                                    r_state  <= S_CALC;
                                end
`else
                                r_acc_hi <= '0;
                                r_acc_lo <= bus.op[1] ? w_mag_a : w_mag_b;
                                r_opb    <= bus.op[1] ? w_mag_b : w_mag_a;
                                r_state  <= S_CALC;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (r_is_div) begin
                            r_acc_hi <= w_q_bit ? w_diff : w_rem_sh[WIDTH-1:0];
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_q_bit};
                        end else begin
                            {r_acc_hi, r_acc_lo} <= {w_mul_sum, r_acc_lo[WIDTH-1:1]};
                        end
                        // counter parks at the last value; it is reloaded at the next accept
                        if (r_cnt == LAST_CNT) begin
                            r_state <= S_FIX;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_FIX: begin
                    // flush wins over the result write
                    if (!bus.flush) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                        r_done <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready = (r_state == S_IDLE);
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.done  = r_done;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard testbench for muldiv_ctrl
module tb_muldiv_ctrl;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk;
    logic rst_n;

    muldiv_ctrl_if #(.WIDTH(32)) bus ();

    muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest queued {hi,lo}
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", {bus.hi, bus.lo}, 64'hx);
            end else begin
                check("hilo", {bus.hi, bus.lo}, sb_q.pop_front());
            end
        end
    end

    task automatic expect_hilo(input logic [31:0] h, input logic [31:0] l);
        m_hi = h;
        m_lo = l;
        sb_q.push_back({h, l});
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 100 && !bus.ready; i++) @(negedge clk);
        check("ready_before_issue", 64'(bus.ready), 64'd1);
        bus.req = 1'b1;
        bus.op  = op;
        bus.a   = a;
        bus.b   = b;
        @(posedge clk);
        #1 bus.req = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc, output logic rdy);
        bit got = 0;
        lat = 0;
        bc  = 0;
        rdy = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1;
                rdy = bus.ready;
            end else begin
                lat++;
                if (bus.busy) bc++;
            end
        end
        if (!got) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int elat);
        int lat, bc;
        logic rdy;
        expect_hilo(eh, el);
        issue(op, a, b);
        wait_done(lat, bc, rdy);
        check("latency", 64'(lat), 64'(elat));
        check("busy_cycles", 64'(bc), 64'(elat));
        check("ready_with_done", 64'(rdy), 64'd1);
    endtask

    initial begin
        int lat, bc;
        logic rdy;
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc;
        logic rdy;
        rst_n     = 1'b0;
        bus.req   = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.ready), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // preload HI/LO, then reset in the middle of a DIV
        expect_hilo(32'h11111111, 32'h0);
        issue(3'd4, 32'h11111111, 32'h0);
        expect_hilo(32'h11111111, 32'h22222222);
        issue(3'd5, 32'h22222222, 32'h0);
        repeat (2) @(negedge clk);
        issue(3'd2, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("midrst_ready", 64'(bus.ready), 64'd1);
        check("midrst_done", 64'(bus.done), 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(3'd1, 32'd3, 32'd5, 32'h0, 32'h0000000F, MUL_LAT);
        run(3'd0, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, MUL_LAT);
        run(3'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT);
        run(3'd3, 32'h7, 32'h2, 32'h1, 32'h3, DIV_LAT);
        run(3'd3, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, DIV_LAT);
        run(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DIV_LAT);
        run(3'd2, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'h00000001, DIV_LAT);
        run(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, MUL_LAT);
        run(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT);

        // flush in CALC cycle 20
        expect_hilo(32'hAAAA0000, m_lo);
        issue(3'd4, 32'hAAAA0000, 32'h0);
        @(negedge clk);
        issue(3'd2, 32'd1000, 32'd3);
        repeat (19) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("flush_calc_ready", 64'(bus.ready), 64'd1);
        check("flush_calc_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
        repeat (40) @(negedge clk);

        // flush on the FIX edge
        issue(3'd3, 32'd1000, 32'd3);
        repeat (32) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("flush_fix_ready", 64'(bus.ready), 64'd1);
        check("flush_fix_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
        repeat (40) @(negedge clk);

        // back-to-back MTHI / MTLO
        expect_hilo(32'h0000BEEF, m_lo);
        expect_hilo(32'h0000BEEF, 32'h0000CAFE);
        bus.req = 1'b1;
        bus.op  = 3'd4;
        bus.a   = 32'h0000BEEF;
        @(posedge clk);
        #1 bus.op = 3'd5;
        bus.a = 32'h0000CAFE;
        @(posedge clk);
        #1 bus.req = 1'b0;
        repeat (3) @(negedge clk);

        // req while busy is ignored
        expect_hilo(32'd2, 32'd14);
        issue(3'd3, 32'd100, 32'd7);
        bus.req = 1'b1;
        bus.op  = 3'd4;
        bus.a   = 32'hDEADDEAD;
        repeat (3) @(posedge clk);
        #1 bus.req = 1'b0;
        wait_done(lat, bc, rdy);

        // illegal op 6 is ignored
        @(negedge clk);
        bus.req = 1'b1;
        bus.op  = 3'd6;
        bus.a   = 32'h5555AAAA;
        @(posedge clk);
        #1 bus.req = 1'b0;
        repeat (3) @(negedge clk);
        check("op6_ready", 64'(bus.ready), 64'd1);
        check("op6_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
